// File: rtl/sc_sng_if.sv
// Handshake and data bundle between the SC stream consumer and the stochastic number generator bank.
interface sc_sng_if #(
    parameter int unsigned N        = 16,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned LEN_W    = N + 1
);
    logic                     start_i;
    logic                     enable_i;
    logic [N-1:0]             seed_i;
    logic [N-1:0]             taps_i;
    logic [LEN_W-1:0]         length_i;
    logic [CHANNELS*N-1:0]    value_i;
    logic [CHANNELS-1:0]      stream_out_o;
    logic                     stream_valid_o;
    logic                     busy_o;
    logic                     done_o;
    logic [N-1:0]             lfsr0_state_o;

    modport master (
        output start_i, enable_i, seed_i, taps_i, length_i, value_i,
        input  stream_out_o, stream_valid_o, busy_o, done_o, lfsr0_state_o
    );

    modport slave (
        input  start_i, enable_i, seed_i, taps_i, length_i, value_i,
        output stream_out_o, stream_valid_o, busy_o, done_o, lfsr0_state_o
    );
endinterface

// File: rtl/sc_sng_bank.sv
// Multi-channel stochastic number generator: per-channel de Bruijn LFSR compared
// against a binary operand, framed by a start/busy/done handshake with enable stall.
module sc_sng_bank #(
    parameter int unsigned   N            = 16,
    parameter int unsigned   CHANNELS     = 4,
    parameter logic [N-1:0]  DEFAULT_TAPS = N'(16'hB400),
    parameter int unsigned   LEN_W        = N + 1
) (
    input  logic        clk,
    input  logic        rst,
    sc_sng_if.slave     bus
);
    localparam int unsigned ROT = N / CHANNELS;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e                         state_q, state_d;
    logic [N-1:0]                   taps_q, taps_d;
    logic [LEN_W-1:0]               len_q, len_d;
    logic [LEN_W-1:0]               cnt_q, cnt_d;
    logic [CHANNELS-1:0][N-1:0]     val_q, val_d;
    logic [CHANNELS-1:0][N-1:0]     lfsr_q, lfsr_d;
    logic [CHANNELS-1:0]            out_q, out_d;
    logic                           valid_q, valid_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;

    logic [CHANNELS-1:0][N-1:0]     lfsr_nxt;
    logic [CHANNELS-1:0][N-1:0]     seed_rot;
    logic [CHANNELS-1:0]            cmp_bits;

    function automatic logic [N-1:0] rotl(input logic [N-1:0] x, input int unsigned k);
        int unsigned kk;
        kk = k % N;
        return (x << kk) | (x >> (N - kk));
    endfunction

    // Per-channel LFSR successor (zero-state inserted after 10..0), seeding and comparator
    always_comb begin
        lfsr_nxt = '0;
        seed_rot = '0;
        cmp_bits = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            lfsr_nxt[c] = {lfsr_q[c][N-2:0],
                           (^(lfsr_q[c] & taps_q)) ^ (lfsr_q[c][N-2:0] == '0)};
            seed_rot[c] = rotl(bus.seed_i, c * ROT);
            cmp_bits[c] = (lfsr_q[c] < val_q[c]);
        end
    end

    always_comb begin
        state_d = state_q;
        taps_d  = taps_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        lfsr_d  = lfsr_q;
        out_d   = out_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                if (bus.start_i) begin
                    taps_d = bus.taps_i;
                    len_d  = bus.length_i;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                    for (int unsigned c = 0; c < CHANNELS; c++) begin
                        val_d[c]  = bus.value_i[c*N +: N];
                        lfsr_d[c] = seed_rot[c];
                    end
                    if (bus.length_i == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // Final bit registers on the same edge that enters DONE
                if (bus.enable_i) begin
                    out_d   = cmp_bits;
                    valid_d = 1'b1;
                    lfsr_d  = lfsr_nxt;
                    cnt_d   = cnt_q + LEN_W'(1);
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            taps_q  <= DEFAULT_TAPS;
            len_q   <= '0;
            cnt_q   <= '0;
            val_q   <= '0;
            lfsr_q  <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            taps_q  <= taps_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            lfsr_q  <= lfsr_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.stream_out_o   = out_q;
    assign bus.stream_valid_o = valid_q;
    assign bus.busy_o         = busy_q;
    assign bus.done_o         = done_q;
    assign bus.lfsr0_state_o  = lfsr_q[0];

endmodule

// File: tb/tb_sc_sng_bank.sv
// Directed scoreboard bench for sc_sng_bank with N=8, two channels.
module tb_sc_sng_bank;
    localparam int unsigned N  = 8;
    localparam int unsigned CH = 2;
    localparam int unsigned LW = N + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sc_sng_if #(.N(N), .CHANNELS(CH), .LEN_W(LW)) bus ();

    sc_sng_bank #(.N(N), .CHANNELS(CH), .DEFAULT_TAPS(8'hB8), .LEN_W(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [CH-1:0] bits;
        logic          last;
    } exp_t;

    exp_t sbq[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   n_valid, n_ones0, n_ones1, n_done;
    logic exp_zero_done = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [N-1:0] model_step(input logic [N-1:0] s, input logic [N-1:0] t);
        logic fb;
        fb = (^(s & t)) ^ (s[N-2:0] == '0);
        return {s[N-2:0], fb};
    endfunction

    function automatic logic [N-1:0] model_rotl(input logic [N-1:0] x, input int unsigned k);
        logic [N-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < N; i++) r[(i + k) % N] = x[i];
        return r;
    endfunction

    task automatic push_stream(input logic [N-1:0] seed, input logic [N-1:0] taps,
                               input int len, input logic [CH*N-1:0] value);
        logic [CH-1:0][N-1:0] s;
        exp_t e;
        for (int unsigned c = 0; c < CH; c++) s[c] = model_rotl(seed, c * (N / CH));
        for (int i = 0; i < len; i++) begin
            for (int unsigned c = 0; c < CH; c++) begin
                e.bits[c] = (s[c] < value[c*N +: N]);
                s[c] = model_step(s[c], taps);
            end
            e.last = (i == len - 1);
            sbq.push_back(e);
        end
    endtask

    task automatic clear_stats();
        n_valid = 0; n_ones0 = 0; n_ones1 = 0; n_done = 0;
    endtask

    // Advance one clock and check whatever the DUT presents against the scoreboard
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (bus.stream_valid_o) begin
            n_valid++;
            n_ones0 += int'(bus.stream_out_o[0]);
            n_ones1 += int'(bus.stream_out_o[1]);
            chk("valid_has_expected", 32'(sbq.size() > 0), 32'd1);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("stream_bits", 32'(bus.stream_out_o), 32'(e.bits));
                chk("done_with_last", 32'(bus.done_o), 32'(e.last));
            end
        end else if (bus.done_o) begin
            chk("done_without_bit_zero_len", 32'(exp_zero_done), 32'd1);
        end
        if (bus.done_o) n_done++;
    endtask

    task automatic start_stream(input logic [N-1:0] seed, input int len,
                                input logic [CH*N-1:0] value);
        bus.seed_i   = seed;
        bus.taps_i   = 8'hB8;
        bus.length_i = LW'(len);
        bus.value_i  = value;
        bus.start_i  = 1'b1;
        push_stream(seed, 8'hB8, len, value);
        tick();
        bus.start_i  = 1'b0;
        bus.seed_i   = ~seed;
        bus.value_i  = ~value;
    endtask

    task automatic wait_done(input int target, input int budget);
        int k;
        k = 0;
        while (n_done < target && k < budget) begin
            tick();
            k++;
        end
        chk("done_timeout", 32'(n_done >= target), 32'd1);
    endtask

    initial begin
        int k;
        rst = 1'b1;
        bus.start_i = 1'b0; bus.enable_i = 1'b1;
        bus.seed_i = '0; bus.taps_i = '0; bus.length_i = '0; bus.value_i = '0;
        clear_stats();

        // Reset state
        tick(); tick();
        chk("rst_stream_out", 32'(bus.stream_out_o), 32'd0);
        chk("rst_valid", 32'(bus.stream_valid_o), 32'd0);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_done", 32'(bus.done_o), 32'd0);
        chk("rst_lfsr0", 32'(bus.lfsr0_state_o), 32'd0);
        rst = 1'b0;
        tick();

        // Full-period exactness run
        clear_stats();
        start_stream(8'h01, 256, {8'd200, 8'd64});
        chk("t1_busy_after_start", 32'(bus.busy_o), 32'd1);
        chk("t1_no_valid_at_start", 32'(bus.stream_valid_o), 32'd0);
        wait_done(1, 400);
        tick();
        chk("t1_valid_count", 32'(n_valid), 32'd256);
        chk("t1_ones_ch0", 32'(n_ones0), 32'd64);
        chk("t1_ones_ch1", 32'(n_ones1), 32'd200);
        chk("t1_done_count", 32'(n_done), 32'd1);
        chk("t1_idle_busy", 32'(bus.busy_o), 32'd0);

        // Zero seed walks through the inserted all-zero state
        clear_stats();
        start_stream(8'h00, 3, {8'hFF, 8'hFF});
        chk("t2_lfsr0_a", 32'(bus.lfsr0_state_o), 32'h00);
        tick();
        chk("t2_lfsr0_b", 32'(bus.lfsr0_state_o), 32'h01);
        tick();
        chk("t2_lfsr0_c", 32'(bus.lfsr0_state_o), 32'h02);
        wait_done(1, 10);
        tick();
        chk("t2_ones_ch0", 32'(n_ones0), 32'd3);
        chk("t2_valid_count", 32'(n_valid), 32'd3);

        // Zero-length stream
        clear_stats();
        exp_zero_done = 1'b1;
        start_stream(8'h11, 0, {8'd5, 8'd5});
        chk("t3_done", 32'(bus.done_o), 32'd1);
        chk("t3_busy", 32'(bus.busy_o), 32'd1);
        chk("t3_valid", 32'(bus.stream_valid_o), 32'd0);
        tick();
        exp_zero_done = 1'b0;
        chk("t3_done_clear", 32'(bus.done_o), 32'd0);
        chk("t3_busy_clear", 32'(bus.busy_o), 32'd0);
        tick();
        chk("t3_valid_count", 32'(n_valid), 32'd0);

        // Enable stall pattern 1,0,0 repeating
        clear_stats();
        start_stream(8'hC3, 10, {8'd90, 8'd170});
        k = 0;
        while (n_done == 0 && k < 100) begin
            bus.enable_i = ((k % 3) == 0);
            tick();
            k++;
        end
        bus.enable_i = 1'b1;
        chk("t4_done_edge", 32'(k), 32'd28);
        tick();
        chk("t4_valid_count", 32'(n_valid), 32'd10);
        chk("t4_done_count", 32'(n_done), 32'd1);

        // Reset in the middle of a stream
        clear_stats();
        start_stream(8'h5A, 20, {8'd30, 8'd100});
        k = 0;
        while (n_valid < 5 && k < 50) begin
            tick();
            k++;
        end
        chk("t5_reach_bit5", 32'(n_valid), 32'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sbq.delete();
        chk("t5_rst_out", 32'(bus.stream_out_o), 32'd0);
        chk("t5_rst_valid", 32'(bus.stream_valid_o), 32'd0);
        chk("t5_rst_busy", 32'(bus.busy_o), 32'd0);
        chk("t5_rst_done", 32'(bus.done_o), 32'd0);
        chk("t5_rst_lfsr0", 32'(bus.lfsr0_state_o), 32'd0);
        tick(); tick();
        chk("t5_stays_idle", 32'(bus.busy_o), 32'd0);
        chk("t5_no_done", 32'(n_done), 32'd0);
        clear_stats();
        start_stream(8'h5A, 20, {8'd30, 8'd100});
        wait_done(1, 60);
        tick();
        chk("t5_rerun_count", 32'(n_valid), 32'd20);

        // Back-to-back via held start, and start ignored while running
        clear_stats();
        bus.seed_i = 8'h33; bus.taps_i = 8'hB8; bus.length_i = LW'(4);
        bus.value_i = {8'd128, 8'd77};
        bus.start_i = 1'b1;
        push_stream(8'h33, 8'hB8, 4, {8'd128, 8'd77});
        push_stream(8'h33, 8'hB8, 4, {8'd128, 8'd77});
        tick();
        wait_done(1, 20);
        tick();
        bus.start_i = 1'b0;
        chk("t6_no_idle_gap_busy", 32'(bus.busy_o), 32'd1);
        chk("t6_no_idle_gap_done", 32'(bus.done_o), 32'd0);
        tick(); tick();
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        wait_done(2, 20);
        tick(); tick();
        chk("t6_valid_count", 32'(n_valid), 32'd8);
        chk("t6_done_count", 32'(n_done), 32'd2);
        chk("t6_queue_empty", 32'(sbq.size()), 32'd0);
        chk("t6_idle", 32'(bus.busy_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/sc_sng_bank.md
Name: sc_sng_bank

Overview:
- Multi-channel stochastic number generator for the SC datapath.
- Each channel owns a parametrised Fibonacci LFSR. The LFSR has a runtime-programmable tap mask and a zero-state (de Bruijn) extension, giving a full 2^N period.
- Each channel compares its LFSR state against a binary operand and emits one stochastic bit per cycle for a programmed stream length.
- A start/busy/done handshake with an enable stall input frames each stream for the downstream SC arithmetic units.

Parameters:
- N, 16, LFSR and operand width in bits (N >= 3).
- CHANNELS, 4, number of independent generator channels.
- DEFAULT_TAPS, 16'hB400, tap mask loaded at reset. Bit i set means state[i] feeds the XOR. Bit N-1 must be set.
- LEN_W, N+1, stream length counter width (max length 2^N).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  start request; accepted in IDLE or DONE only
- enable  in  1  advance permission; low in RUN stalls LFSRs, counter and output
- seed  in  N  base seed, sampled on accepted start
- taps  in  N  tap mask, sampled on accepted start
- length  in  LEN_W  stream length in bits, sampled on accepted start
- value  in  CHANNELS*N  per-channel unsigned operand; channel c is bits [c*N +: N]; sampled on accepted start
- stream_out  out  CHANNELS  registered stochastic bit per channel
- stream_valid  out  1  stream_out holds a fresh bit this cycle
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse on the final bit
- lfsr0_state  out  N  channel 0 LFSR state, for debug/observability

Behaviour:
- Reset (sync): state=IDLE, all LFSRs=0, tap register=DEFAULT_TAPS, counter=0, stream_out=0, stream_valid=0, busy=0, done=0. Reset wins over all other inputs, including mid-RUN; the stream is abandoned and no done is issued.
- LFSR next state, per channel: s' = {s[N-2:0], fb}.
  - fb = (^(s & taps_reg)) ^ (s[N-2:0] == 0).
  - The zero term inserts the all-zero state, so the sequence is 10..0 -> 00..0 -> 00..01.
  - With primitive taps the period is exactly 2^N; an all-zero seed is legal.
- Channel seeding: on accepted start, channel c LFSR <= seed rotated left by c*(N/CHANNELS) (integer division); channel 0 gets seed unchanged.
- Comparator: bit_c = (lfsr_c < value_c), unsigned, N-bit.
- FSM states and transitions:
  - IDLE: start=1 latches seed/taps/length/value, loads LFSRs, clears counter. If length==0, goes to DONE with no valid bits; else goes to RUN. start=0 stays in IDLE.
  - RUN, on a cycle with enable=1, at the clock edge:
    - stream_out <= bit vector from the current LFSR states; stream_valid <= 1.
    - LFSRs advance; counter++.
    - If counter == length-1 before the increment, next state is DONE; else stay in RUN.
    - This registers the final bit at the same edge as the transition, so it appears in the first DONE cycle.
  - RUN with enable=0: stream_valid <= 0; LFSRs, counter and stream_out hold.
  - DONE, one cycle: done=1. stream_valid is 1 in this cycle if length>0 (final bit visible), 0 if length==0. The next cycle either accepts a new start (back-to-back, same as IDLE) or returns to IDLE.
- start in RUN is ignored. value/seed/taps changes after acceptance have no effect.
- Latency: start accepted at edge t; first stream_valid in the cycle after edge t+1 (given enable=1). The bit presented equals (rot(seed) < value).
- Exactness: with length=2^N and primitive taps, each channel visits every N-bit state once, so the count of ones equals value_c exactly.

Test Plan:
- N=8, CHANNELS=2, taps=8'hB8, seed=8'h01, length=256, value={8'd200,8'd64}, enable=1 -> exactly 256 valid bits; ch0 ones=64, ch1 ones=200; done pulses once with the 256th valid bit.
- N=8, seed=8'h00, length=3, value=8'hFF -> lfsr0_state sequence 00,01,02; all three ch0 bits =1.
- length=0 start -> one-cycle done, busy for 1 cycle, stream_valid never high.
- N=8, length=10, enable toggled 1,0,0,1,... -> exactly 10 valid bits. The bit sequence is identical to the enable=1 run; done is delayed by the stall count.
- rst asserted at bit 5 of a length=20 run -> next cycle all outputs 0, state IDLE, no done. A new start then reproduces the run from its seed.
- start held high through DONE -> back-to-back stream begins with no IDLE cycle; a start pulse during RUN is ignored (bit count unchanged).
